// File: rtl/edac_mem_ctrl.sv
// edac_mem_ctrl: single-port memory controller that routes every access through an external registered EDAC
module edac_mem_ctrl #(
    parameter logic [31:0] ERROR_CODE = 32'hFFFFFFFF,
    parameter logic        SCRUB_EN   = 1'b1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        REQ,
    input  logic        WR,
    input  logic [4:0]  ADDR,
    input  logic [31:0] WDATA,
    output logic        ACK,
    output logic [31:0] RDATA,
    output logic        ERR,
    output logic [7:0]  ERR_CNT,
    output logic        BUSY,
    output logic [4:0]  MEM_ADDR,
    input  logic [31:0] MEM_DOUT,
    output logic        MEM_WE,
    output logic [31:0] MEM_DIN,
    input  logic [31:0] LUT_DOUT,
    output logic        LUT_WE,
    output logic [31:0] LUT_DIN,
    output logic        EDAC_EN,
    output logic        EDAC_READ,
    output logic [31:0] EDAC_DIN,
    output logic [31:0] EDAC_LUT,
    input  logic        EDAC_VALID,
    input  logic [31:0] EDAC_DOUT,
    input  logic [31:0] EDAC_NEW_LUT
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;
    state_t      state_q;
    logic [4:0]  addr_q;
    logic        wr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [7:0]  err_cnt_q;
    logic        issue;
    logic        capt;
    logic        rd_fail;
    assign issue   = state_q == ISSUE;
    assign capt    = state_q == CAPT;
    assign rd_fail = (EDAC_DOUT == ERROR_CODE) || !EDAC_VALID;
    // Strobes are qualified by reset so a reset landing mid-transaction aborts it in the same cycle
    assign ACK       = (state_q == RESP) && !reset;
    assign BUSY      = state_q != IDLE;
    assign MEM_ADDR  = addr_q;
    assign EDAC_EN   = issue && !reset;
    assign EDAC_READ = issue && !wr_q;
    assign EDAC_DIN  = issue ? (wr_q ? wdata_q : MEM_DOUT) : 32'h0;
    assign EDAC_LUT  = issue ? LUT_DOUT : 32'h0;
    assign MEM_WE    = capt && wr_q && !reset;
    assign LUT_WE    = capt && !reset && (wr_q || (SCRUB_EN && !rd_fail));
    assign MEM_DIN   = EDAC_DOUT;
    assign LUT_DIN   = EDAC_NEW_LUT;
    assign RDATA     = rdata_q;
    assign ERR       = err_q;
    assign ERR_CNT   = err_cnt_q;
    // Transaction sequencer: latch request, one cycle in the EDAC, capture its result, acknowledge
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= 5'h0;
            wr_q      <= 1'b0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (REQ) begin
                        state_q <= ISSUE;
                        addr_q  <= ADDR;
                        wr_q    <= WR;
                        wdata_q <= WDATA;
                    end
                end
                ISSUE: state_q <= CAPT;
                CAPT: begin
                    state_q <= RESP;
                    if (wr_q) begin
                        err_q <= 1'b0;
                    end else if (rd_fail) begin
                        rdata_q   <= ERROR_CODE;
                        err_q     <= 1'b1;
                        err_cnt_q <= (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                    end else begin
                        rdata_q <= EDAC_DOUT;
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_edac_mem_ctrl.sv
// tb_edac_mem_ctrl: directed bench with RAM/EDAC environment and a latency-based transaction model
module tb_edac_mem_ctrl;
    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        REQ = 1'b0;
    logic        WR = 1'b0;
    logic [4:0]  ADDR = 5'h0;
    logic [31:0] WDATA = 32'h0;
    logic        ACK, ERR, BUSY, MEM_WE, LUT_WE, EDAC_EN, EDAC_READ;
    logic [31:0] RDATA, MEM_DIN, LUT_DIN, EDAC_DIN, EDAC_LUT, MEM_DOUT, LUT_DOUT;
    logic [7:0]  ERR_CNT;
    logic [4:0]  MEM_ADDR;
    logic        EDAC_VALID = 1'b0;
    logic [31:0] EDAC_DOUT = 32'h0;
    logic [31:0] EDAC_NEW_LUT = 32'h0;
    logic [31:0] mem [32];
    logic [31:0] lut [32];
    logic [31:0] cfg_dout = 32'h0;
    logic [31:0] cfg_lut = 32'h0;
    logic        cfg_valid = 1'b1;
    int checks = 0;
    int failures = 0;
    int ack_cnt = 0;
    int cyc = 0;
    logic [31:0] last_din = 32'h0;
    bit          have = 0;
    int          n = 0;
    logic        m_wr = 0;
    logic [4:0]  m_addr = 0;
    logic [31:0] m_wdata = 0, m_rdata = 0, m_dout = 0, m_lut = 0;
    logic        m_valid = 0, m_err = 0;
    logic [7:0]  m_cnt = 0;

    edac_mem_ctrl dut (
        .CLK(CLK), .reset(reset), .REQ(REQ), .WR(WR), .ADDR(ADDR), .WDATA(WDATA),
        .ACK(ACK), .RDATA(RDATA), .ERR(ERR), .ERR_CNT(ERR_CNT), .BUSY(BUSY),
        .MEM_ADDR(MEM_ADDR), .MEM_DOUT(MEM_DOUT), .MEM_WE(MEM_WE), .MEM_DIN(MEM_DIN),
        .LUT_DOUT(LUT_DOUT), .LUT_WE(LUT_WE), .LUT_DIN(LUT_DIN),
        .EDAC_EN(EDAC_EN), .EDAC_READ(EDAC_READ), .EDAC_DIN(EDAC_DIN), .EDAC_LUT(EDAC_LUT),
        .EDAC_VALID(EDAC_VALID), .EDAC_DOUT(EDAC_DOUT), .EDAC_NEW_LUT(EDAC_NEW_LUT)
    );

    always #5 CLK = ~CLK;

    assign MEM_DOUT = mem[MEM_ADDR];
    assign LUT_DOUT = lut[MEM_ADDR];

    // Data and LUT RAMs with synchronous write
    always @(posedge CLK) begin
        if (MEM_WE) mem[MEM_ADDR] = MEM_DIN;
        if (LUT_WE) lut[MEM_ADDR] = LUT_DIN;
    end

    // Registered EDAC stand-in returning the configured response when enabled
    always @(posedge CLK) begin
        if (EDAC_EN) begin
            EDAC_DOUT    <= cfg_dout;
            EDAC_NEW_LUT <= cfg_lut;
            EDAC_VALID   <= cfg_valid;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the transaction model, then advance the model
    always @(negedge CLK) begin
        int  k;
        bit  act, fail;
        k    = cyc - n;
        act  = have && k >= 1 && k <= 3;
        fail = (m_dout == 32'hFFFFFFFF) || !m_valid;
        chk("busy", BUSY, act);
        chk("mem_addr", MEM_ADDR, m_addr);
        chk("ack", ACK, act && k == 3 && !reset);
        chk("mem_we", MEM_WE, act && k == 2 && m_wr && !reset);
        chk("lut_we", LUT_WE, act && k == 2 && !reset && (m_wr || !fail));
        if (act && k == 2 && m_wr && !reset) chk("mem_din", MEM_DIN, m_dout);
        if (act && k == 2 && !reset && (m_wr || !fail)) chk("lut_din", LUT_DIN, m_lut);
        if (!reset) chk("edac_en", EDAC_EN, act && k == 1);
        if (act && k == 1 && !reset) begin
            chk("edac_read", EDAC_READ, !m_wr);
            chk("edac_din", EDAC_DIN, m_wr ? m_wdata : mem[m_addr]);
            chk("edac_lut", EDAC_LUT, lut[m_addr]);
        end
        chk("rdata", RDATA, m_rdata);
        chk("err", ERR, m_err);
        chk("err_cnt", ERR_CNT, m_cnt);
        if (ACK) ack_cnt++;
        if (EDAC_EN) last_din = EDAC_DIN;
        if (reset) begin
            have = 0; m_addr = 0; m_wr = 0; m_wdata = 0;
            m_rdata = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (act && k == 2) begin
                if (m_wr) m_err = 0;
                else if (fail) begin
                    m_rdata = 32'hFFFFFFFF;
                    m_err = 1;
                    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                end else begin
                    m_rdata = m_dout;
                    m_err = 0;
                end
            end
            if (!act && REQ) begin
                have = 1; n = cyc; m_wr = WR; m_addr = ADDR; m_wdata = WDATA;
                m_dout = cfg_dout; m_lut = cfg_lut; m_valid = cfg_valid;
            end
        end
        cyc++;
    end

    task automatic txn(input logic w, input logic [4:0] a, input logic [31:0] d);
        REQ = 1; WR = w; ADDR = a; WDATA = d;
        @(posedge CLK); #1 REQ = 0;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic cfg(input logic [31:0] d, input logic [31:0] l, input logic v);
        cfg_dout = d; cfg_lut = l; cfg_valid = v;
    endtask

    initial begin
        int a0;
        logic [31:0] m3;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'h100 + i;
            lut[i] = 32'h0;
        end
        mem[7] = 32'hCAFE_0000;
        repeat (3) @(posedge CLK);
        #1 reset = 0;
        chk("rst_rdata", RDATA, 32'h0);
        chk("rst_err", ERR, 0);
        chk("rst_cnt", ERR_CNT, 8'h0);
        chk("rst_busy", BUSY, 0);
        chk("rst_addr", MEM_ADDR, 5'h0);
        @(posedge CLK); #1;
        // write through the EDAC
        cfg(32'hA5A5_0001, 32'h0000_00C3, 1);
        a0 = ack_cnt;
        txn(1, 5'h03, 32'h1234_5678);
        chk("wr_mem", mem[3], 32'hA5A5_0001);
        chk("wr_lut", lut[3], 32'h0000_00C3);
        chk("wr_err", ERR, 0);
        chk("wr_rdata", RDATA, 32'h0);
        chk("wr_acks", ack_cnt - a0, 1);
        // good read with scrub
        cfg(32'h0000_BEEF, 32'h0000_0055, 1);
        txn(0, 5'h07, 32'h0);
        chk("rd_din", last_din, 32'hCAFE_0000);
        chk("rd_rdata", RDATA, 32'h0000_BEEF);
        chk("rd_err", ERR, 0);
        chk("rd_scrub", lut[7], 32'h0000_0055);
        chk("rd_mem", mem[7], 32'hCAFE_0000);
        // reset during CAPT of a write
        cfg(32'hDEAD_0000, 32'h77, 1);
        m3 = mem[3];
        a0 = ack_cnt;
        REQ = 1; WR = 1; ADDR = 5'h03; WDATA = 32'h5;
        @(posedge CLK); #1 REQ = 0;
        @(posedge CLK); #1 reset = 1;
        @(posedge CLK); #1 reset = 0;
        chk("abort_busy", BUSY, 0);
        chk("abort_rdata", RDATA, 32'h0);
        repeat (3) @(posedge CLK); #1;
        chk("abort_mem", mem[3], m3);
        chk("abort_lut", lut[3], 32'h0000_00C3);
        chk("abort_acks", ack_cnt - a0, 0);
        // failed reads: error code, then invalid, then saturation
        cfg(32'hFFFF_FFFF, 32'h99, 1);
        txn(0, 5'h04, 32'h0);
        chk("fail_rdata", RDATA, 32'hFFFF_FFFF);
        chk("fail_err", ERR, 1);
        chk("fail_cnt", ERR_CNT, 8'h01);
        chk("fail_lut", lut[4], 32'h0);
        cfg(32'h0000_1111, 32'h99, 0);
        txn(0, 5'h05, 32'h0);
        chk("inval_rdata", RDATA, 32'hFFFF_FFFF);
        chk("inval_cnt", ERR_CNT, 8'h02);
        for (int i = 0; i < 253; i++) txn(0, 5'(i), 32'h0);
        chk("sat_255", ERR_CNT, 8'hFF);
        txn(0, 5'h01, 32'h0);
        chk("sat_256", ERR_CNT, 8'hFF);
        txn(0, 5'h02, 32'h0);
        chk("sat_257", ERR_CNT, 8'hFF);
        cfg(32'h0BAD_F00D, 32'h11, 1);
        txn(0, 5'h07, 32'h0);
        chk("recover_rdata", RDATA, 32'h0BAD_F00D);
        chk("recover_err", ERR, 0);
        // REQ held high: one ACK every 4 cycles
        a0 = ack_cnt;
        REQ = 1; WR = 0; ADDR = 5'h09;
        repeat (20) @(posedge CLK);
        #1 REQ = 0;
        repeat (4) @(posedge CLK); #1;
        chk("held_acks", ack_cnt - a0, 5);
        // REQ pulses while busy are ignored
        a0 = ack_cnt;
        REQ = 1; ADDR = 5'h0A;
        @(posedge CLK); #1 REQ = 1;
        @(posedge CLK); #1 REQ = 0;
        @(posedge CLK); #1 REQ = 1;
        @(posedge CLK); #1 REQ = 0;
        repeat (4) @(posedge CLK); #1;
        chk("pulse_acks", ack_cnt - a0, 1);
        // reset wins over simultaneous REQ
        a0 = ack_cnt;
        reset = 1; REQ = 1;
        @(posedge CLK); #1 reset = 0; REQ = 0;
        chk("rstreq_busy", BUSY, 0);
        chk("rstreq_cnt", ERR_CNT, 8'h0);
        repeat (4) @(posedge CLK); #1;
        chk("rstreq_acks", ack_cnt - a0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/edac_mem_ctrl.md
EDAC_MEM_CTRL -- requirements
Module: edac_mem_ctrl

Interface
REQ-001 SHALL have parameter ERROR_CODE, default 32'hFFFFFFFF, the EDAC "uncorrectable" output word.
REQ-002 SHALL have parameter SCRUB_EN, default 1'b1; 1 writes the decoder's updated LUT word back on every good read.
REQ-003 SHALL have ports:
- CLK  in  1  system clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- REQ  in  1  request strobe; sampled in IDLE only.
- WR  in  1  1 = write, 0 = read; sampled with REQ.
- ADDR  in  5  word address; sampled with REQ.
- WDATA  in  32  write data; sampled with REQ.
- ACK  out  1  one-cycle completion pulse.
- RDATA  out  32  read result.
- ERR  out  1  read failed; valid with ACK and held until the next ACK.
- ERR_CNT  out  8  saturating count of failed reads.
- BUSY  out  1  high whenever the state is not IDLE.
- MEM_ADDR  out  5  address to data RAM and LUT RAM.
- MEM_DOUT  in  32  data RAM asynchronous read data at MEM_ADDR.
- MEM_WE  out  1  data RAM write strobe.
- MEM_DIN  out  32  data RAM write data.
- LUT_DOUT  in  32  LUT RAM asynchronous read data at MEM_ADDR.
- LUT_WE  out  1  LUT RAM write strobe.
- LUT_DIN  out  32  LUT RAM write data.
- EDAC_EN  out  1  EDAC enable.
- EDAC_READ  out  1  EDAC mode; 1 = decode, 0 = encode.
- EDAC_DIN  out  32  EDAC data input.
- EDAC_LUT  out  32  EDAC LUT input.
- EDAC_VALID  in  1  EDAC registered valid.
- EDAC_DOUT  in  32  EDAC registered data output.
- EDAC_NEW_LUT  in  32  EDAC registered LUT output.

Function
REQ-004 SHALL implement the FSM IDLE -> ISSUE -> CAPT -> RESP -> IDLE; every transition is unconditional except IDLE->ISSUE, which requires REQ=1.
REQ-005 SHALL, on the IDLE->ISSUE transition, latch ADDR, WR and WDATA into internal registers; the latched values drive the whole transaction.
REQ-006 SHALL ignore REQ in ISSUE, CAPT and RESP; requests are neither queued nor acknowledged.
REQ-007 SHALL drive MEM_ADDR from the latched address in ISSUE, CAPT and RESP, and hold its last value in IDLE.
REQ-008 SHALL, in ISSUE only, drive:
- EDAC_EN=1 and EDAC_READ=~WR_latched;
- EDAC_DIN = WR_latched ? WDATA_latched : MEM_DOUT;
- EDAC_LUT = LUT_DOUT.
REQ-009 SHALL hold EDAC_EN=0 in every state other than ISSUE.
REQ-010 SHALL, for a write in CAPT, assert MEM_WE=1 with MEM_DIN=EDAC_DOUT, and assert LUT_WE=1 with LUT_DIN=EDAC_NEW_LUT, both for exactly one cycle.
REQ-011 SHALL, for a read in CAPT, classify the read as failed when EDAC_DOUT==ERROR_CODE or EDAC_VALID==0.
REQ-012 SHALL, for a failed read:
- register RDATA=ERROR_CODE and ERR=1;
- leave MEM_WE=0 and LUT_WE=0;
- increment ERR_CNT, saturating at 8'hFF.
REQ-013 SHALL, for a good read:
- register RDATA=EDAC_DOUT and ERR=0;
- if SCRUB_EN=1, assert LUT_WE=1 for one cycle with LUT_DIN=EDAC_NEW_LUT;
- keep MEM_WE=0.
REQ-014 SHALL register ERR=0 on a completed write and leave RDATA unchanged.
REQ-015 SHALL assert ACK=1 for exactly the one RESP cycle.
REQ-016 SHALL give a latency of REQ sampled in cycle n -> ACK in cycle n+3; the earliest next acceptance is cycle n+4.
REQ-017 SHALL keep MEM_WE and LUT_WE low in every state except CAPT.
REQ-018 SHALL assert BUSY=1 in ISSUE, CAPT and RESP.

Reset
REQ-019 SHALL, when reset=1 at a CLK edge, move the FSM to IDLE and clear:
- ACK, ERR, BUSY, MEM_WE, LUT_WE and EDAC_EN to 0;
- RDATA to 32'h0, ERR_CNT to 8'h0 and MEM_ADDR to 5'h0;
- the latched ADDR, WR and WDATA to 0.
REQ-020 SHALL, on a reset asserted mid-transaction (ISSUE, CAPT or RESP), abort the transaction: no write strobe and no ACK is issued for it.
REQ-021 SHALL give reset priority over a simultaneous REQ; the request is dropped.

Verification
REQ-022 SHALL show: write ADDR=5'h03, WDATA=32'h1234_5678, model EDAC_DOUT=32'hA5A5_0001 and NEW_LUT=32'h0000_00C3 -> MEM_WE and LUT_WE each pulse at n+2 with those values, ACK at n+3, ERR=0.
REQ-023 SHALL show: read ADDR=5'h07, MEM_DOUT=32'hCAFE_0000, model EDAC_DOUT=32'h0000_BEEF with valid=1 -> EDAC_DIN=32'hCAFE_0000 in ISSUE, RDATA=32'h0000_BEEF, ERR=0, LUT_WE pulse, MEM_WE never asserted.
REQ-024 SHALL show: read with model EDAC_DOUT=32'hFFFF_FFFF -> RDATA=32'hFFFF_FFFF, ERR=1, no write strobes, ERR_CNT increments from 0 to 1.
REQ-025 SHALL show: 256 failed reads -> ERR_CNT=8'hFF, then stays 8'hFF on the 257th.
REQ-026 SHALL show: REQ held high continuously -> one ACK every 4 cycles, and REQ pulses in ISSUE, CAPT or RESP produce no extra ACK.
REQ-027 SHALL show: reset asserted during CAPT of a write -> MEM_WE=0 that cycle, no ACK, FSM in IDLE, all outputs at reset values on the next cycle.
